// File: rtl/mem_arbiter_pkg.sv
// Shared encodings, widths and payload types for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned TAG_W    = 4;
  localparam int unsigned NUM_TAGS = 16;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_e;

  typedef enum logic {
    ARB_IF = 1'b0,
    ARB_DM = 1'b1
  } arb_port_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bus_cmd_e          command;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals seen by the arbiter.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic [ADDR_W-1:0] if2arb_addr;
  logic [1:0]        if2arb_command;
  logic [TAG_W-1:0]  arb2if_response;
  logic [DATA_W-1:0] arb2if_data;
  logic [TAG_W-1:0]  arb2if_tag;

  logic [ADDR_W-1:0] dm2arb_addr;
  logic [DATA_W-1:0] dm2arb_data;
  logic [1:0]        dm2arb_command;
  logic [TAG_W-1:0]  arb2dm_response;
  logic [DATA_W-1:0] arb2dm_data;
  logic [TAG_W-1:0]  arb2dm_tag;

  logic [ADDR_W-1:0] arb2mem_addr;
  logic [DATA_W-1:0] arb2mem_data;
  logic [1:0]        arb2mem_command;
  logic [TAG_W-1:0]  mem2arb_response;
  logic [DATA_W-1:0] mem2arb_data;
  logic [TAG_W-1:0]  mem2arb_tag;

  // Arbiter side
  modport slave (
    input  if2arb_addr, if2arb_command,
    output arb2if_response, arb2if_data, arb2if_tag,
    input  dm2arb_addr, dm2arb_data, dm2arb_command,
    output arb2dm_response, arb2dm_data, arb2dm_tag,
    output arb2mem_addr, arb2mem_data, arb2mem_command,
    input  mem2arb_response, mem2arb_data, mem2arb_tag
  );

  // Requester/memory side
  modport master (
    output if2arb_addr, if2arb_command,
    input  arb2if_response, arb2if_data, arb2if_tag,
    output dm2arb_addr, dm2arb_data, dm2arb_command,
    input  arb2dm_response, arb2dm_data, arb2dm_tag,
    input  arb2mem_addr, arb2mem_data, arb2mem_command,
    output mem2arb_response, mem2arb_data, mem2arb_tag
  );
endinterface

// File: rtl/mem_tag_table.sv
// 16-entry outstanding-load table: valid bit and owning port per tag.
module mem_tag_table
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  arb_port_e        set_owner,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic [TAG_W-1:0] look_tag,
  output logic             look_valid,
  output arb_port_e        look_owner
);

  logic [NUM_TAGS-1:0] valid;
  logic [NUM_TAGS-1:0] owner;

  // Clear first, then set, so a same-cycle set on the same tag wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      owner <= '0;
    end else begin
      if (clr_en) valid[clr_tag] <= 1'b0;
      if (set_en) begin
        valid[set_tag] <= 1'b1;
        owner[set_tag] <= set_owner;
      end
    end
  end

  // Combinational lookup for the returning tag
  always_comb begin
    look_valid = valid[look_tag];
    look_owner = arb_port_e'(owner[look_tag]);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between fetch and data ports: data priority, fetch anti-starvation,
// and tag-based steering of returned load data.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             if_req;
  logic             dm_req;
  logic             grant_valid;
  arb_port_e        grant;
  mem_req_t         req;
  logic [CNT_W-1:0] starve_cnt;
  logic             issue_load;
  logic             ret_valid;
  arb_port_e        ret_owner;
  logic             ret_hit;

  // Pick the winner: data unless fetch has been denied STARVE_LIMIT times in a row
  always_comb begin
    if_req      = bus.if2arb_command != BUS_NONE;
    dm_req      = bus.dm2arb_command != BUS_NONE;
    grant_valid = if_req || dm_req;
    grant       = ARB_DM;
    if (if_req && (!dm_req || starve_cnt == LIMIT)) grant = ARB_IF;
  end

  // Steer the winner onto the memory bus and the issue response back to it
  always_comb begin
    req             = '0;
    bus.arb2if_response = '0;
    bus.arb2dm_response = '0;
    if (grant_valid) begin
      if (grant == ARB_IF) begin
        req.addr            = bus.if2arb_addr;
        req.command         = bus_cmd_e'(bus.if2arb_command);
        bus.arb2if_response = bus.mem2arb_response;
      end else begin
        req.addr            = bus.dm2arb_addr;
        req.data            = bus.dm2arb_data;
        req.command         = bus_cmd_e'(bus.dm2arb_command);
        bus.arb2dm_response = bus.mem2arb_response;
      end
    end
    bus.arb2mem_addr    = req.addr;
    bus.arb2mem_data    = req.data;
    bus.arb2mem_command = req.command;
    issue_load          = grant_valid && req.command == BUS_LOAD && bus.mem2arb_response != '0;
  end

  // A fetch grant that memory rejects keeps the count, so fetch stays ahead until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req) begin
      starve_cnt <= '0;
    end else if (grant == ARB_IF) begin
      if (bus.mem2arb_response != '0) starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  mem_tag_table u_tag_table (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue_load),
    .set_tag   (bus.mem2arb_response),
    .set_owner (grant),
    .clr_en    (ret_hit),
    .clr_tag   (bus.mem2arb_tag),
    .look_tag  (bus.mem2arb_tag),
    .look_valid(ret_valid),
    .look_owner(ret_owner)
  );

  // Route returned data to the tag's owner; unknown or zero tags are dropped
  always_comb begin
    ret_hit         = bus.mem2arb_tag != '0 && ret_valid;
    bus.arb2if_tag  = '0;
    bus.arb2if_data = '0;
    bus.arb2dm_tag  = '0;
    bus.arb2dm_data = '0;
    if (ret_hit) begin
      if (ret_owner == ARB_IF) begin
        bus.arb2if_tag  = bus.mem2arb_tag;
        bus.arb2if_data = bus.mem2arb_data;
      end else begin
        bus.arb2dm_tag  = bus.mem2arb_tag;
        bus.arb2dm_data = bus.mem2arb_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed scoreboard bench for mem_arbiter.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned LIMIT = 4;

  typedef struct {
    logic [3:0]  if_resp;
    logic [3:0]  dm_resp;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic [1:0]  mcmd;
    logic [3:0]  if_tag;
    logic [31:0] if_data;
    logic [3:0]  dm_tag;
    logic [31:0] dm_data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t q[$];
  int   owner_of[16];   // -1 = no outstanding load, 0 = fetch, 1 = data
  int   denials;        // consecutive cycles fetch asked and lost
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // One cycle of stimulus; the reference model predicts the outputs and advances its state
  task automatic cycle(input logic r, input logic [1:0] ic, input logic [31:0] ia,
                       input logic [1:0] dc, input logic [31:0] da, input logic [31:0] dd,
                       input logic [3:0] resp, input logic [3:0] rtag, input logic [31:0] rdata);
    exp_t e;
    int   win;
    bit   if_req, dm_req;
    logic [1:0] wcmd;
    @(posedge clk);
    #1;
    rst                  = r;
    bus.if2arb_command   = ic;
    bus.if2arb_addr      = ia;
    bus.dm2arb_command   = dc;
    bus.dm2arb_addr      = da;
    bus.dm2arb_data      = dd;
    bus.mem2arb_response = resp;
    bus.mem2arb_tag      = rtag;
    bus.mem2arb_data     = rdata;

    if (r) begin
      denials = 0;
      foreach (owner_of[i]) owner_of[i] = -1;
    end

    e = '{default: '0};
    if_req = ic != BUS_NONE;
    dm_req = dc != BUS_NONE;
    win = -1;
    if (if_req && dm_req) win = (denials == int'(LIMIT)) ? 0 : 1;
    else if (if_req)      win = 0;
    else if (dm_req)      win = 1;
    wcmd = BUS_NONE;
    if (win == 0) begin
      e.if_resp = resp; e.maddr = ia; e.mcmd = ic; wcmd = ic;
    end else if (win == 1) begin
      e.dm_resp = resp; e.maddr = da; e.mdata = dd; e.mcmd = dc; wcmd = dc;
    end
    if (rtag != 0 && owner_of[rtag] == 0) begin
      e.if_tag = rtag; e.if_data = rdata;
    end else if (rtag != 0 && owner_of[rtag] == 1) begin
      e.dm_tag = rtag; e.dm_data = rdata;
    end
    q.push_back(e);

    if (!r) begin
      if (rtag != 0) owner_of[rtag] = -1;
      if (win >= 0 && wcmd == BUS_LOAD && resp != 0) owner_of[resp] = win;
      if (!if_req)                denials = 0;
      else if (win == 0)          denials = (resp != 0) ? 0 : denials;
      else if (denials < int'(LIMIT)) denials = denials + 1;
    end
  endtask

  task automatic idle(input logic [3:0] rtag, input logic [31:0] rdata);
    cycle(1'b0, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 32'h0, 4'h0, rtag, rdata);
  endtask

  // Monitor: compare every cycle the DUT presents outputs against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("if_response",  32'(bus.arb2if_response), 32'(e.if_resp));
        chk("dm_response",  32'(bus.arb2dm_response), 32'(e.dm_resp));
        chk("mem_addr",     bus.arb2mem_addr,         e.maddr);
        chk("mem_data",     bus.arb2mem_data,         e.mdata);
        chk("mem_command",  32'(bus.arb2mem_command), 32'(e.mcmd));
        chk("if_tag",       32'(bus.arb2if_tag),      32'(e.if_tag));
        chk("if_data",      bus.arb2if_data,          e.if_data);
        chk("dm_tag",       32'(bus.arb2dm_tag),      32'(e.dm_tag));
        chk("dm_data",      bus.arb2dm_data,          e.dm_data);
      end
    end
  end

  initial begin
    int outstanding[$];
    logic [1:0]  ic, dc;
    logic [3:0]  resp, rtag;
    int guard;

    denials = 0;
    foreach (owner_of[i]) owner_of[i] = -1;
    rst = 1'b1;
    bus.if2arb_command = BUS_NONE; bus.if2arb_addr = '0;
    bus.dm2arb_command = BUS_NONE; bus.dm2arb_addr = '0; bus.dm2arb_data = '0;
    bus.mem2arb_response = '0; bus.mem2arb_tag = '0; bus.mem2arb_data = '0;

    // Reset state: everything idle reads as zero, even with a stray return tag
    cycle(1'b1, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0);
    cycle(1'b1, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 32'h0, 4'h0, 4'h3, 32'h55);
    idle(4'h0, 32'h0);

    // Fetch-only load, then its data comes back on the fetch port
    cycle(1'b0, BUS_LOAD, 32'h100, BUS_NONE, 32'h0, 32'h0, 4'h3, 4'h0, 32'h0);
    idle(4'h0, 32'h0);
    idle(4'h3, 32'hDEADBEEF);

    // Both ports loading continuously: data x4, fetch, data
    for (int i = 0; i < 6; i++)
      cycle(1'b0, BUS_LOAD, 32'h400 + 32'(i), BUS_LOAD, 32'h800 + 32'(i), 32'h0,
            4'(9 + i), 4'h0, 32'h0);
    for (int t = 9; t <= 14; t++) idle(4'(t), 32'hA000 + 32'(t));

    // Store does not allocate a tag; its later return is dropped
    cycle(1'b0, BUS_NONE, 32'h0, BUS_STORE, 32'h200, 32'h12345678, 4'h5, 4'h0, 32'h0);
    idle(4'h5, 32'hBAD0BAD0);

    // Interleaved loads returned out of order
    cycle(1'b0, BUS_NONE, 32'h0, BUS_LOAD, 32'h300, 32'h0, 4'h2, 4'h0, 32'h0);
    cycle(1'b0, BUS_LOAD, 32'h104, BUS_NONE, 32'h0, 32'h0, 4'h7, 4'h0, 32'h0);
    idle(4'h7, 32'h77777777);
    idle(4'h2, 32'h22222222);
    idle(4'h7, 32'h77770000);
    idle(4'h2, 32'h22220000);

    // Same-cycle return and reissue of tag 4
    cycle(1'b0, BUS_LOAD, 32'h108, BUS_NONE, 32'h0, 32'h0, 4'h4, 4'h0, 32'h0);
    cycle(1'b0, BUS_NONE, 32'h0, BUS_LOAD, 32'h304, 32'h0, 4'h4, 4'h4, 32'h44440001);
    idle(4'h4, 32'h44440002);

    // Build up fetch denials with three loads outstanding, then reset
    cycle(1'b0, BUS_LOAD, 32'h10C, BUS_LOAD, 32'h308, 32'h0, 4'h1, 4'h0, 32'h0);
    cycle(1'b0, BUS_LOAD, 32'h10C, BUS_LOAD, 32'h30C, 32'h0, 4'h6, 4'h0, 32'h0);
    cycle(1'b0, BUS_LOAD, 32'h10C, BUS_LOAD, 32'h310, 32'h0, 4'h8, 4'h0, 32'h0);
    cycle(1'b0, BUS_LOAD, 32'h10C, BUS_STORE, 32'h314, 32'h9, 4'hF, 4'h0, 32'h0);
    cycle(1'b1, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0);
    cycle(1'b1, BUS_NONE, 32'h0, BUS_NONE, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0);
    idle(4'h1, 32'h11);
    idle(4'h6, 32'h66);
    idle(4'h8, 32'h88);
    cycle(1'b0, BUS_LOAD, 32'h110, BUS_LOAD, 32'h318, 32'h0, 4'h9, 4'h0, 32'h0);
    idle(4'h9, 32'h99);

    // Randomized traffic, including busy responses and stale returns
    for (int n = 0; n < 2000; n++) begin
      ic = ($urandom_range(0, 2) != 0) ? BUS_LOAD : BUS_NONE;
      case ($urandom_range(0, 2))
        0:       dc = BUS_NONE;
        1:       dc = BUS_LOAD;
        default: dc = BUS_STORE;
      endcase
      resp = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      outstanding.delete();
      foreach (owner_of[i]) if (owner_of[i] >= 0) outstanding.push_back(i);
      if (outstanding.size() > 0 && $urandom_range(0, 1) == 1)
        rtag = 4'(outstanding[$urandom_range(0, outstanding.size() - 1)]);
      else
        rtag = 4'($urandom_range(0, 15));
      cycle(1'b0, ic, $urandom, dc, $urandom, $urandom, resp, rtag, $urandom);
    end
    idle(4'h0, 32'h0);

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #2;
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one unified `mem` instance between the processor's instruction-fetch port and its data-memory port. The arbiter replaces the separate IM/DM memory instances in the processor bench. It grants one requester per cycle, with data priority and anti-starvation for fetch. It records which requester owns each outstanding load tag and steers returned data to that owner.

## Interface
- `STARVE_LIMIT`, 4: consecutive fetch denials after which fetch is forced to win one cycle (1..15).
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `if2arb_addr`  in  32  fetch address
- `if2arb_command`  in  2  fetch command (BUS_NONE or BUS_LOAD only)
- `arb2if_response`  out  4  issue tag returned to fetch (0 = not accepted)
- `arb2if_data`  out  32  returned load data for fetch
- `arb2if_tag`  out  4  tag of `arb2if_data` (0 = no data)
- `dm2arb_addr`  in  32  data address
- `dm2arb_data`  in  32  store data
- `dm2arb_command`  in  2  BUS_NONE / BUS_LOAD / BUS_STORE
- `arb2dm_response`, `arb2dm_data`, `arb2dm_tag`  out  4/32/4  same meaning as the fetch outputs, for the data port
- `arb2mem_addr`, `arb2mem_data`, `arb2mem_command`  out  32/32/2  request to `mem`
- `mem2arb_response`, `mem2arb_data`, `mem2arb_tag`  in  4/32/4  from `mem`

## Operation
- Grant (combinational):
  - If only one port has a non-NONE command, that port wins.
  - If both request, the data port wins unless `starve_cnt == STARVE_LIMIT`. In that case fetch wins.
  - The winner's addr/data/command drive `mem`. When neither port requests, `mem` sees BUS_NONE with addr/data 0.
- Issue response: `mem2arb_response` goes to the granted port's `*_response`. The other port gets 0.
  - A zero response means busy. The requester holds its request and retries. The arbiter does not buffer requests.
- Starvation counter `starve_cnt` (4 bits):
  - Increments when fetch requests and the data port is granted.
  - Clears when fetch is granted or fetch is not requesting.
  - Saturates at `STARVE_LIMIT`.
  - A busy (zero) response does not change the counter beyond these rules.
- Tag table (16 entries: `valid`, `owner`):
  - On a granted BUS_LOAD with nonzero response T: set `valid[T]=1` and `owner[T]` = grantee.
  - Stores do not allocate entries.
- Data return:
  - If `mem2arb_tag = T != 0` and `valid[T]`, drive `mem2arb_data` and T to the owner's data/tag outputs. Drive the other port's tag as 0. Clear `valid[T]` at the next edge.
  - If `valid[T]` is 0 (stale or unexpected), drop it. Both tag outputs are 0.
  - Tag 0 is never allocated or routed.
- Same-cycle return of T and a new issue receiving T: the return routes to the old owner, and the table entry is re-set for the new grantee (set wins over clear).
- Output data buses are 0 whenever the corresponding tag output is 0.

## Timing
- Grant, response steering and data steering are combinational: 0-cycle latency. Table and counter update on `posedge clk`.
- Reset (asynchronous):
  - `starve_cnt=0`, all `valid=0`, `owner=0`.
  - Every output is combinational from inputs. With both ports at BUS_NONE and mem idle, all outputs are 0.
- Reset during outstanding loads: entries are lost, and later returns of those tags are dropped. Requesters must also be reset.
- Worst-case fetch wait under continuous data traffic: `STARVE_LIMIT` denied cycles, then a grant on the next cycle. This holds only if mem accepts (response nonzero); otherwise fetch keeps priority while `starve_cnt == STARVE_LIMIT`.

## Structure
- BUS_NONE/BUS_LOAD/BUS_STORE encodings come from `sys_defs.vh`.
- Add the port-id enum `ARB_IF`/`ARB_DM` to `sys_defs.vh`.
- One sub-module, `mem_tag_table`: 16-entry valid/owner store with set port, clear port and lookup port, set-over-clear priority. Grant logic and counter live in `mem_arbiter`.

## Test plan
- Fetch-only LOAD addr 0x100, mem response 3 → `arb2if_response=3`, `arb2dm_response=0`. Later tag 3 with data 0xDEADBEEF → `arb2if_data=0xDEADBEEF`, `arb2if_tag=3`, `arb2dm_tag=0`.
- Both ports LOAD, `STARVE_LIMIT=4`, mem always accepts → data granted 4 cycles, fetch granted cycle 5, counter returns to 0, data granted cycle 6.
- DM STORE addr 0x200 data 0x12345678, response 5 → mem sees STORE/0x200/0x12345678. A later return of tag 5 is dropped: both tag outputs 0.
- Interleaved loads: DM tag 2, IF tag 7. Mem returns tag 7 then tag 2 → each port's data arrives on its own port, and `valid` bits clear.
- Return of tag 4 in the same cycle that a new DM load is issued tag 4 (old owner IF) → IF receives the data, and the next return of tag 4 goes to DM.
- Assert `rst` with 3 loads outstanding, then return their tags → all dropped, outputs 0, `starve_cnt=0`.
